// File: rtl/gpi_pkg.sv
// gpi_pkg: register offsets and edge-select encoding for the APB GPI block
package gpi_pkg;
  localparam logic [4:0] GPI_CR  = 5'h00;
  localparam logic [4:0] GPI_IDR = 5'h04;
  localparam logic [4:0] GPI_IER = 5'h08;
  localparam logic [4:0] GPI_ITR = 5'h0C;
  localparam logic [4:0] GPI_ISR = 5'h10;
  localparam logic [4:0] GPI_DBR = 5'h14;
  typedef enum logic {EDGE_RISE, EDGE_FALL} edge_t;
endpackage

// File: rtl/gpi_debounce.sv
// gpi_debounce: one pin's synchroniser, debounce counter and stable/delayed-stable state
module gpi_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            din,
  input  logic [DB_W-1:0] dbr,
  input  logic            dbr_wr,
  output logic            stable,
  output logic            stable_d
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // sync chain, debounce filter and one-cycle delayed copy for edge detection
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      sync_q   <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      stable_d <= stable;
      if (dbr == '0) begin
        stable <= sync;
        cnt    <= '0;
      end else if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == dbr - DB_W'(1)) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
      if (dbr_wr) cnt <= '0;
    end
  end
endmodule

// File: rtl/apb_gpi_irq.sv
// apb_gpi_irq: APB general-purpose input port with debounce, edge capture and level interrupt
module apb_gpi_irq
  import gpi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [4:0]       PADDR,
  input  logic             PWRITE,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);
  logic [WIDTH-1:0] cr, ier, itr, isr, stable, stable_d, evt, wdat;
  logic [DB_W-1:0]  dbr;
  logic [31:0]      rd_data;
  logic [4:0]       off;
  logic             acc, wr, rd, dbr_wr, unused_bits;

  assign off         = {PADDR[4:2], 2'b00};
  assign acc         = PSEL & PENABLE & ~PREADY;
  assign wr          = acc & PWRITE;
  assign rd          = acc & ~PWRITE;
  assign dbr_wr      = wr && off == GPI_DBR;
  assign wdat        = PWDATA[WIDTH-1:0];
  assign irq         = |(isr & ier);
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpi_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W)) u_db (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .din      (gpi[i]),
      .dbr      (dbr),
      .dbr_wr   (dbr_wr),
      .stable   (stable[i]),
      .stable_d (stable_d[i])
    );
    assign evt[i] = cr[i] & ((edge_t'(itr[i]) == EDGE_FALL) ? (stable_d[i] & ~stable[i])
                                                            : (~stable_d[i] & stable[i]));
  end

  // read mux over the register map; unmapped offsets read zero
  always_comb begin
    rd_data = '0;
    case (off)
      GPI_CR:  rd_data = 32'(cr);
      GPI_IDR: rd_data = 32'(stable & cr);
      GPI_IER: rd_data = 32'(ier);
      GPI_ITR: rd_data = 32'(itr);
      GPI_ISR: rd_data = 32'(isr);
      GPI_DBR: rd_data = 32'(dbr);
      default: rd_data = '0;
    endcase
  end

  // one-wait-state APB handshake, register writes and sticky status with set-over-clear
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
      cr     <= '0;
      ier    <= '0;
      itr    <= '0;
      isr    <= '0;
      dbr    <= '0;
    end else begin
      PREADY <= acc;
      if (rd) PRDATA <= rd_data;
      if (wr && off == GPI_CR)  cr  <= wdat;
      if (wr && off == GPI_IER) ier <= wdat;
      if (wr && off == GPI_ITR) itr <= wdat;
      if (dbr_wr) dbr <= PWDATA[DB_W-1:0];
      isr <= (isr & ~((wr && off == GPI_ISR) ? wdat : '0)) | evt;
    end
  end
endmodule

// File: tb/tb_apb_gpi_irq.sv
// tb_apb_gpi_irq: directed self-checking bench for apb_gpi_irq
module tb_apb_gpi_irq;
  import gpi_pkg::*;

  logic        PCLK, PRESET, PWRITE, PSEL, PENABLE, irq, PREADY;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA, PRDATA, rdv;
  logic [7:0]  gpi;
  int          passed, total;

  apb_gpi_irq #(.WIDTH(8), .SYNC_STAGES(2), .DB_W(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .gpi(gpi), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apb(input logic w, input logic [4:0] a, input logic [31:0] d, output logic [31:0] q);
    PSEL = 1'b1; PWRITE = w; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("pready_hi", 32'(PREADY), 32'd1);
    q = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK);
    chk("pready_lo", 32'(PREADY), 32'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] q;
    apb(1'b1, a, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] q;
    apb(1'b0, a, 32'd0, q);
    chk(tag, q, exp);
  endtask

  initial begin
    passed = 0; total = 0;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; gpi = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    PRESET = 1'b1;
    @(negedge PCLK);
    for (int i = 0; i < 8; i++) rd_chk("rst_reg", 5'(i * 4), 32'd0);
    wr(GPI_CR, 32'hA5);
    rd_chk("cr_rb", GPI_CR, 32'hA5);
    wr(5'h18, 32'hFF);
    rd_chk("unmapped", 5'h18, 32'd0);
    wr(GPI_CR, 32'h01);
    wr(GPI_IER, 32'h01);
    wr(GPI_ITR, 32'h00);
    gpi[0] = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rise_early", 32'(irq), 32'd0);
    @(negedge PCLK);
    chk("rise_irq", 32'(irq), 32'd1);
    rd_chk("rise_isr", GPI_ISR, 32'h01);
    rd_chk("rise_idr", GPI_IDR, 32'h01);
    wr(GPI_ISR, 32'h01);
    chk("w1c_irq", 32'(irq), 32'd0);
    rd_chk("w1c_isr", GPI_ISR, 32'h00);
    wr(GPI_ITR, 32'h02);
    wr(GPI_CR, 32'h02);
    wr(GPI_IER, 32'h00);
    gpi[1] = 1'b1;
    repeat (6) @(negedge PCLK);
    rd_chk("fall_norise", GPI_ISR, 32'h00);
    gpi[1] = 1'b0;
    repeat (6) @(negedge PCLK);
    rd_chk("fall_isr", GPI_ISR, 32'h02);
    chk("fall_masked", 32'(irq), 32'd0);
    wr(GPI_IER, 32'h02);
    chk("fall_irq", 32'(irq), 32'd1);
    wr(GPI_ISR, 32'h02);
    wr(GPI_IER, 32'h00);
    wr(GPI_DBR, 32'd4);
    wr(GPI_ITR, 32'h00);
    wr(GPI_CR, 32'h04);
    wr(GPI_IER, 32'h04);
    rd_chk("dbr_rb", GPI_DBR, 32'd4);
    gpi[2] = 1'b1;
    repeat (3) @(negedge PCLK);
    gpi[2] = 1'b0;
    repeat (10) @(negedge PCLK);
    rd_chk("glitch_isr", GPI_ISR, 32'h00);
    rd_chk("glitch_idr", GPI_IDR, 32'h00);
    gpi[2] = 1'b1;
    repeat (6) @(negedge PCLK);
    chk("db_early", 32'(irq), 32'd0);
    @(negedge PCLK);
    chk("db_irq", 32'(irq), 32'd1);
    repeat (3) @(negedge PCLK);
    gpi[2] = 1'b0;
    rd_chk("db_isr", GPI_ISR, 32'h04);
    repeat (10) @(negedge PCLK);
    rd_chk("db_idr_low", GPI_IDR, 32'h00);
    wr(GPI_ISR, 32'h04);
    wr(GPI_DBR, 32'd0);
    wr(GPI_IER, 32'h01);
    wr(GPI_CR, 32'h01);
    gpi[0] = 1'b0;
    repeat (6) @(negedge PCLK);
    rd_chk("pre_coll_isr", GPI_ISR, 32'h00);
    gpi[0] = 1'b1;
    repeat (2) @(negedge PCLK);
    wr(GPI_ISR, 32'h01);
    chk("coll_irq", 32'(irq), 32'd1);
    rd_chk("coll_isr", GPI_ISR, 32'h01);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = GPI_ISR; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    chk("mid_pready", 32'(PREADY), 32'd1);
    chk("mid_prdata", PRDATA, 32'h01);
    PRESET = 1'b0;
    #1;
    chk("arst_pready", 32'(PREADY), 32'd0);
    chk("arst_prdata", PRDATA, 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    rd_chk("arst_isr", GPI_ISR, 32'h00);
    rd_chk("arst_cr", GPI_CR, 32'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
